// File: rtl/booth_mult_65_if.sv
// Operand/result bundle for the iterative Booth multiplier in the multdiv path.
// The master side drives start and operands; the slave (multiplier) returns results.
interface booth_mult_65_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] product;
  logic [31:0] product_hi;
  logic        overflow;
  logic        ready;
  logic        busy;

  modport master (
    output start, multiplicand, multiplier,
    input  product, product_hi, overflow, ready, busy
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, product_hi, overflow, ready, busy
  );
endinterface

// File: rtl/booth_mult_65.sv
// Radix-2 Booth signed 32x32 multiplier on a 65-bit {hi, lo, q-1} working register.
// One iteration per clock; a result is retired 32 cycles after the start edge.
//
// state | meaning
// IDLE  | waiting for start; P holds the last result (or zeros after clr)
// RUN   | one Booth add/sub + arithmetic shift per edge, 32 edges total
// DONE  | single-cycle ready pulse; P frozen with the finished product
module booth_mult_65 (
  input  logic               clk,
  input  logic               clr,
  booth_mult_65_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [64:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] acc;
  logic [32:0] acc_next;
  logic [32:0] m_ext;

  // 33-bit accumulator keeps M = 0x80000000 exact through the add/sub.
  always_comb begin
    acc   = {p_q[64], p_q[64:33]};
    m_ext = {m_q[31], m_q};
    case (p_q[1:0])
      2'b01:   acc_next = acc + m_ext;
      2'b10:   acc_next = acc - m_ext;
      default: acc_next = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    if (bus.start) begin
      // A start in any state restarts; an in-flight result is abandoned.
      m_d     = bus.multiplicand;
      p_d     = {32'b0, bus.multiplier, 1'b0};
      cnt_d   = 5'd0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          p_d   = {acc_next, p_q[32:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      p_q     <= 65'd0;
      m_q     <= 32'd0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.product    = p_q[32:1];
  assign bus.product_hi = p_q[64:33];
  assign bus.overflow   = (p_q[64:33] != {32{p_q[32]}});
  assign bus.ready      = (state_q == DONE);
  assign bus.busy       = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_65.sv
// Directed + randomized bench for booth_mult_65 against a 64-bit integer-multiply model.
module tb_booth_mult_65;
  logic clk;
  logic clr;
  int   total;
  int   bad;

  booth_mult_65_if bus ();

  booth_mult_65 dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: full signed product and its 32-bit fit test.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
    longint fa;
    longint fb;
    longint f;
    logic [31:0] lo;
    logic ov;
    fa = longint'($signed(a));
    fb = longint'($signed(b));
    f  = fa * fb;
    lo = f[31:0];
    ov = (f != longint'($signed(lo)));
    return {ov, f[63:0]};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    step();
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  // Wait (bounded) for ready; returns cycles after the start edge and busy count.
  task automatic wait_ready(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (!bus.ready && cyc < 40) begin
      if (bus.busy) bcnt++;
      step();
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    e = model(a, b);
    chk({tag, ".ready"}, 64'(bus.ready), 64'(1'b1));
    chk({tag, ".lo"}, 64'(bus.product), 64'(e[31:0]));
    chk({tag, ".hi"}, 64'(bus.product_hi), 64'(e[63:32]));
    chk({tag, ".ovf"}, 64'(bus.overflow), 64'(e[64]));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int bcnt;
    launch(a, b);
    wait_ready(cyc, bcnt);
    chk({tag, ".lat"}, 64'(cyc), 64'(32));
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(32));
    check_result(tag, a, b);
  endtask

  initial begin
    int cyc;
    int bcnt;
    int rdy_seen;
    logic [31:0] a;
    logic [31:0] b;
    logic [64:0] e;
    total = 0;
    bad   = 0;
    bus.start        = 1'b0;
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    chk("rst.lo", 64'(bus.product), 64'd0);
    chk("rst.hi", 64'(bus.product_hi), 64'd0);
    chk("rst.ovf", 64'(bus.overflow), 64'd0);
    chk("rst.ready", 64'(bus.ready), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);

    run_op("pos3x5", 32'd3, 32'd5);
    chk("pos3x5.const_lo", 64'(bus.product), 64'h0000000F);
    step();
    chk("pos3x5.ready_drop", 64'(bus.ready), 64'd0);
    chk("pos3x5.idle_busy", 64'(bus.busy), 64'd0);

    run_op("neg7x6", 32'hFFFFFFF9, 32'h00000006);
    chk("neg7x6.const_lo", 64'(bus.product), 64'hFFFFFFD6);
    run_op("minxm1", 32'h80000000, 32'hFFFFFFFF);
    chk("minxm1.const_ovf", 64'(bus.overflow), 64'd1);
    run_op("minxmin", 32'h80000000, 32'h80000000);
    chk("minxmin.const_hi", 64'(bus.product_hi), 64'h40000000);
    run_op("zero", 32'd0, 32'h7FFFFFFF);
    run_op("maxxmax", 32'h7FFFFFFF, 32'h7FFFFFFF);

    // Restart mid-run: only the second operation may complete.
    launch(32'd100, 32'd100);
    repeat (9) step();
    chk("restart.busy_mid", 64'(bus.busy), 64'd1);
    launch(32'd2, 32'hFFFFFFFD);
    wait_ready(cyc, bcnt);
    chk("restart.lat", 64'(cyc), 64'(32));
    check_result("restart", 32'd2, 32'hFFFFFFFD);
    chk("restart.const_lo", 64'(bus.product), 64'hFFFFFFFA);

    // Back-to-back: start asserted during the ready cycle of the first op.
    launch(32'd11, 32'd13);
    wait_ready(cyc, bcnt);
    chk("b2b.first_lat", 64'(cyc), 64'(32));
    check_result("b2b.first", 32'd11, 32'd13);
    launch(32'hFFFF0000, 32'h00012345);
    chk("b2b.busy", 64'(bus.busy), 64'd1);
    chk("b2b.no_ready", 64'(bus.ready), 64'd0);
    wait_ready(cyc, bcnt);
    chk("b2b.second_lat", 64'(cyc), 64'(32));
    check_result("b2b.second", 32'hFFFF0000, 32'h00012345);

    // clr mid-run cancels everything.
    launch(32'd1234, 32'd5678);
    repeat (14) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr.busy", 64'(bus.busy), 64'd0);
    chk("clr.ready", 64'(bus.ready), 64'd0);
    chk("clr.lo", 64'(bus.product), 64'd0);
    chk("clr.hi", 64'(bus.product_hi), 64'd0);
    chk("clr.ovf", 64'(bus.overflow), 64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) rdy_seen++;
      step();
    end
    chk("clr.no_ready", 64'(rdy_seen), 64'd0);

    // clr beats start on the same edge.
    clr = 1'b1;
    bus.start = 1'b1;
    step();
    clr = 1'b0;
    bus.start = 1'b0;
    chk("clr_start.busy", 64'(bus.busy), 64'd0);

    run_op("post_clr7x7", 32'd7, 32'd7);
    chk("post_clr7x7.const_lo", 64'(bus.product), 64'd49);

    // Result holds while operands wiggle without start.
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    run_op("hold", a, b);
    e = model(a, b);
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      step();
      if (bus.ready) rdy_seen++;
    end
    chk("hold.lo", 64'(bus.product), 64'(e[31:0]));
    chk("hold.hi", 64'(bus.product_hi), 64'(e[63:32]));
    chk("hold.ovf", 64'(bus.overflow), 64'(e[64]));
    chk("hold.no_ready", 64'(rdy_seen), 64'd0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 15) - 8;
        1: b = $urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h7FFFFFFF;
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), a, b);
      if ($urandom_range(0, 1) != 0) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
